// File: rtl/sha512_group_fifo_if.sv
// Block FIFO bus bundle: host write side, grouped show-ahead read side, status and error flags.
interface sha512_group_fifo_if #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16,
    parameter int GROUP  = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] enq_data;
    logic              enq_en;
    logic              not_full;
    logic [DATA_W-1:0] deq_data [GROUP];
    logic              deq_en;
    logic              not_empty;
    logic [CW-1:0]     count;
    logic [CW-1:0]     free;
    logic              almost_full;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output enq_data, enq_en, deq_en,
        input  not_full, deq_data, not_empty, count, free,
               almost_full, overflow_err, underflow_err
    );

    modport slave (
        input  enq_data, enq_en, deq_en,
        output not_full, deq_data, not_empty, count, free,
               almost_full, overflow_err, underflow_err
    );
endinterface

// File: rtl/sha512_group_fifo.sv
// Block FIFO for the SHA-512 core: one block in per cycle, GROUP blocks out per pop.
// Optional synchronous flush input is enabled by defining SHA512_GFIFO_FLUSH_EN.
module sha512_group_fifo #(
    parameter int DATA_W   = 512,
    parameter int DEPTH    = 16,
    parameter int GROUP    = 2,
    parameter int AFULL_TH = DEPTH - GROUP
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef SHA512_GFIFO_FLUSH_EN
    input  logic                   flush,
`endif
    sha512_group_fifo_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              flush_w;
    logic              enq_acc, deq_acc;

`ifdef SHA512_GFIFO_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Both requests are qualified on registered flags only; no same-cycle bypass.
    assign enq_acc = bus.enq_en & bus.not_full;
    assign deq_acc = bus.deq_en & bus.not_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq_acc) rd_ptr_d = rd_ptr_q + AW'(GROUP);
            count_d = count_q + CW'(enq_acc) - (deq_acc ? CW'(GROUP) : CW'(0));
            if (bus.enq_en && !bus.not_full)  ovf_d = 1'b1;
            if (bus.deq_en && !bus.not_empty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage carries no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (!reset && !flush_w && enq_acc)
            mem_q[wr_ptr_q] <= bus.enq_data;
    end

    for (genvar g = 0; g < GROUP; g++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx             = rd_ptr_q + AW'(g);
        assign bus.deq_data[g] = mem_q[idx];
    end

    assign bus.count         = count_q;
    assign bus.free          = CW'(DEPTH) - count_q;
    assign bus.not_full      = count_q < CW'(DEPTH);
    assign bus.not_empty     = count_q >= CW'(GROUP);
    assign bus.almost_full   = count_q >= CW'(AFULL_TH);
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_sha512_group_fifo.sv
// Directed self-checking bench for sha512_group_fifo (DEPTH=8, GROUP=2, AFULL_TH=6).
module tb_sha512_group_fifo;
    localparam int DATA_W = 512;
    localparam int DEPTH  = 8;
    localparam int GROUP  = 2;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    sha512_group_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GROUP(GROUP)) bus ();

    sha512_group_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .GROUP(GROUP), .AFULL_TH(6)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SHA512_GFIFO_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        bus.enq_en   = 1'b1;
        bus.enq_data = d;
        step();
        bus.enq_en   = 1'b0;
    endtask

    task automatic pop();
        bus.deq_en = 1'b1;
        step();
        bus.deq_en = 1'b0;
    endtask

    initial begin
        int rd_n;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        flush = 1'b0;
        bus.enq_en = 1'b0;
        bus.deq_en = 1'b0;
        bus.enq_data = '0;
        step();
        step();
        reset = 1'b0;

        chk("rst_count", bus.count, 0);
        chk("rst_free", bus.free, 8);
        chk("rst_not_full", bus.not_full, 1);
        chk("rst_not_empty", bus.not_empty, 0);
        chk("rst_afull", bus.almost_full, 0);
        chk("rst_ovf", bus.overflow_err, 0);
        chk("rst_unf", bus.underflow_err, 0);

        // Basic write three, pop one group
        wr('hA0);
        chk("first_count", bus.count, 1);
        chk("first_not_empty", bus.not_empty, 0);
        wr('hA1);
        wr('hA2);
        chk("t1_count3", bus.count, 3);
        chk("t1_d0", bus.deq_data[0], 'hA0);
        chk("t1_d1", bus.deq_data[1], 'hA1);
        chk("t1_not_empty", bus.not_empty, 1);
        pop();
        chk("t1_count1", bus.count, 1);
        chk("t1_not_empty_low", bus.not_empty, 0);
        chk("t1_free7", bus.free, 7);
        chk("t1_d0_after", bus.deq_data[0], 'hA2);

        // count=1: write accepted, pop refused
        bus.enq_en = 1'b1; bus.enq_data = 'hA3; bus.deq_en = 1'b1;
        step();
        bus.enq_en = 1'b0; bus.deq_en = 1'b0;
        chk("c1_both_count", bus.count, 2);
        chk("c1_both_unf", bus.underflow_err, 1);
        chk("c1_both_ovf", bus.overflow_err, 0);
        chk("c1_d0", bus.deq_data[0], 'hA2);
        chk("c1_d1", bus.deq_data[1], 'hA3);

        // Fill to full and overflow
        do_reset();
        chk("rst2_unf", bus.underflow_err, 0);
        for (int i = 0; i < 5; i++) wr('hC0 + i);
        chk("fill5_afull", bus.almost_full, 0);
        wr('hC5);
        chk("fill6_count", bus.count, 6);
        chk("fill6_afull", bus.almost_full, 1);
        wr('hC6);
        chk("fill7_not_full", bus.not_full, 1);
        wr('hC7);
        chk("fill8_count", bus.count, 8);
        chk("fill8_not_full", bus.not_full, 0);
        chk("fill8_free", bus.free, 0);
        chk("fill8_ovf_pre", bus.overflow_err, 0);
        wr('hEE);
        chk("ovf_count", bus.count, 8);
        chk("ovf_flag", bus.overflow_err, 1);
        chk("ovf_d0", bus.deq_data[0], 'hC0);

        // count=8: pop accepted, write refused
        do_reset();
        for (int i = 0; i < 8; i++) wr('hC0 + i);
        bus.enq_en = 1'b1; bus.enq_data = 'hEF; bus.deq_en = 1'b1;
        step();
        bus.enq_en = 1'b0; bus.deq_en = 1'b0;
        chk("c8_both_count", bus.count, 6);
        chk("c8_both_ovf", bus.overflow_err, 1);
        chk("c8_both_unf", bus.underflow_err, 0);
        chk("c8_d0", bus.deq_data[0], 'hC2);
        chk("c8_d1", bus.deq_data[1], 'hC3);
        pop();
        pop();
        chk("c8_d0_late", bus.deq_data[0], 'hC6);
        chk("c8_d1_late", bus.deq_data[1], 'hC7);
        pop();
        chk("c8_drained", bus.count, 0);

        // Reset mid-operation with both errors set
        pop();
        chk("pre_rst_unf", bus.underflow_err, 1);
        for (int i = 0; i < 8; i++) wr('h10 + i);
        wr('h99);
        pop();
        pop();
        wr('h18);
        chk("pre_rst_count5", bus.count, 5);
        chk("pre_rst_ovf", bus.overflow_err, 1);
        reset = 1'b1; bus.enq_en = 1'b1; bus.enq_data = 'h77;
        step();
        reset = 1'b0; bus.enq_en = 1'b0;
        chk("mrst_count", bus.count, 0);
        chk("mrst_not_full", bus.not_full, 1);
        chk("mrst_not_empty", bus.not_empty, 0);
        chk("mrst_ovf", bus.overflow_err, 0);
        chk("mrst_unf", bus.underflow_err, 0);

        // Wrap-around stream: 20 writes, pop every other cycle
        rd_n = 0;
        for (int c = 0; c < 21; c++) begin
            bus.enq_en   = (c < 20);
            bus.enq_data = 'hB0 + c;
            bus.deq_en   = (c >= 2) && (c % 2 == 0);
            if (bus.deq_en) begin
                chk("wrap_d0", bus.deq_data[0], 'hB0 + rd_n);
                chk("wrap_d1", bus.deq_data[1], 'hB0 + rd_n + 1);
                rd_n += 2;
            end
            step();
        end
        bus.enq_en = 1'b0; bus.deq_en = 1'b0;
        chk("wrap_popped", rd_n, 20);
        chk("wrap_count", bus.count, 0);
        chk("wrap_unf", bus.underflow_err, 0);
        chk("wrap_ovf", bus.overflow_err, 0);

`ifdef SHA512_GFIFO_FLUSH_EN
        do_reset();
        pop();
        chk("fl_pre_unf", bus.underflow_err, 1);
        for (int i = 0; i < 5; i++) wr('hD0 + i);
        chk("fl_pre_count", bus.count, 5);
        flush = 1'b1; bus.enq_en = 1'b1; bus.enq_data = 'hFF; bus.deq_en = 1'b1;
        step();
        flush = 1'b0; bus.enq_en = 1'b0; bus.deq_en = 1'b0;
        chk("fl_count", bus.count, 0);
        chk("fl_not_empty", bus.not_empty, 0);
        chk("fl_unf_kept", bus.underflow_err, 1);
        chk("fl_ovf", bus.overflow_err, 0);
        wr('hE0);
        wr('hE1);
        chk("fl_post_count", bus.count, 2);
        chk("fl_post_d0", bus.deq_data[0], 'hE0);
        chk("fl_post_d1", bus.deq_data[1], 'hE1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
